// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issuer: FSM state codes, op-select codes and instruction field layout.
// The retired-instruction counter in alu_issue_seq is built only when ISSUE_CNT_EN is defined.
package alu_issue_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_READ = 2'd1;
    localparam state_t ST_EXEC = 2'd2;
    localparam state_t ST_WB   = 2'd3;

    localparam logic [2:0] OP_SUB = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_LT  = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    localparam int INSTR_W = 9;
    localparam int OP_LSB  = 6;
    localparam int RD_LSB  = 4;
    localparam int RA_LSB  = 2;
    localparam int RB_LSB  = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        instr_t d;
        d.op = raw[OP_LSB +: 3];
        d.rd = raw[RD_LSB +: 2];
        d.ra = raw[RA_LSB +: 2];
        d.rb = raw[RB_LSB +: 2];
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x4-bit register file: two async read ports, writeback and load write ports (writeback wins
// on an address clash), asynchronous active-low clear.
module alu_regfile
    import alu_issue_pkg::*;
#(
    parameter int REGS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ra_addr_i,
    output logic [3:0] ra_data_o,
    input  logic [1:0] rb_addr_i,
    output logic [3:0] rb_data_o,
    input  logic       wb_en_i,
    input  logic [1:0] wb_addr_i,
    input  logic [3:0] wb_data_i,
    input  logic       ld_en_i,
    input  logic [1:0] ld_addr_i,
    input  logic [3:0] ld_data_i
);

    logic [3:0] rf_q [REGS];

    assign ra_data_o = rf_q[ra_addr_i];
    assign rb_data_o = rf_q[rb_addr_i];

    // Per-entry write select with writeback taking priority over a same-index load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                rf_q[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < REGS; i++) begin
                if (wb_en_i && (wb_addr_i == 2'(i))) begin
                    rf_q[i] <= wb_data_i;
                end else if (ld_en_i && (ld_addr_i == 2'(i))) begin
                    rf_q[i] <= ld_data_i;
                end else begin
                    rf_q[i] <= rf_q[i];
                end
            end
        end
    end

endmodule

// File: rtl/alu_issue_seq.sv
// Four-phase issuer (IDLE/READ/EXEC/WB) feeding an external combinational execute unit.
// Define ISSUE_CNT_EN to add the 8-bit wrapping `retired` counter port.
module alu_issue_seq
    import alu_issue_pkg::*;
#(
    parameter int REGS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [8:0] instr,
    output logic       instr_ready,
    input  logic       load_valid,
    input  logic [1:0] load_addr,
    input  logic [3:0] load_data,
    output logic [3:0] exe_rs,
    output logic [3:0] exe_rt,
    output logic [2:0] exe_sel,
    input  logic [3:0] exe_out,
    output logic       wb_valid,
    output logic [1:0] wb_rd,
    output logic [3:0] wb_data
`ifdef ISSUE_CNT_EN
    ,
    output logic [7:0] retired
`endif
);

    state_t     state_q, state_d;
    logic       ready_q, ready_d;
    instr_t     ins_q, ins_d;
    logic [3:0] exe_rs_q, exe_rs_d;
    logic [3:0] exe_rt_q, exe_rt_d;
    logic [2:0] exe_sel_q, exe_sel_d;
    logic       wb_valid_q, wb_valid_d;
    logic [1:0] wb_rd_q, wb_rd_d;
    logic [3:0] wb_data_q, wb_data_d;
    logic [3:0] rs_rdata_s, rt_rdata_s;

    // wb_data_q doubles as the result register between EXEC and WB.
    alu_regfile #(.REGS(REGS)) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra_addr_i (ins_q.ra),
        .ra_data_o (rs_rdata_s),
        .rb_addr_i (ins_q.rb),
        .rb_data_o (rt_rdata_s),
        .wb_en_i   (state_q == ST_WB),
        .wb_addr_i (wb_rd_q),
        .wb_data_i (wb_data_q),
        .ld_en_i   (load_valid),
        .ld_addr_i (load_addr),
        .ld_data_i (load_data)
    );

    // Next-state and datapath update for the four-phase issue sequence.
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        ins_d      = ins_q;
        exe_rs_d   = exe_rs_q;
        exe_rt_d   = exe_rt_q;
        exe_sel_d  = exe_sel_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    ins_d   = decode_instr(instr);
                    state_d = ST_READ;
                    ready_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_READ: begin
                exe_rs_d  = rs_rdata_s;
                exe_rt_d  = rt_rdata_s;
                exe_sel_d = ins_q.op;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                wb_data_d  = exe_out;
                wb_rd_d    = ins_q.rd;
                wb_valid_d = 1'b1;
                state_d    = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            ins_q      <= '0;
            exe_rs_q   <= 4'd0;
            exe_rt_q   <= 4'd0;
            exe_sel_q  <= 3'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 2'd0;
            wb_data_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            ins_q      <= ins_d;
            exe_rs_q   <= exe_rs_d;
            exe_rt_q   <= exe_rt_d;
            exe_sel_q  <= exe_sel_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign instr_ready = ready_q;
    assign exe_rs      = exe_rs_q;
    assign exe_rt      = exe_rt_q;
    assign exe_sel     = exe_sel_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;

`ifdef ISSUE_CNT_EN
    logic [7:0] retired_q, retired_d;

    // Count each writeback; the 8-bit register wraps naturally.
    always_comb begin
        if (state_q == ST_WB) begin
            retired_d = retired_q + 8'd1;
        end else begin
            retired_d = retired_q;
        end
    end

    // Retired counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 8'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq: a behavioural register-file model predicts each writeback;
// a negedge monitor pops and compares whenever wb_valid is seen.
module tb_alu_issue_seq;
    import alu_issue_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       load_valid;
    logic [1:0] load_addr;
    logic [3:0] load_data;
    logic [3:0] exe_rs, exe_rt, exe_out;
    logic [2:0] exe_sel;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [3:0] wb_data;
`ifdef ISSUE_CNT_EN
    logic [7:0] retired;
`endif

    typedef struct {
        logic [1:0] rd;
        logic [3:0] data;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [2:0] sel;
    } exp_t;

    exp_t       sb_q[$];
    int         acc_q[$];
    logic [3:0] model_rf [4];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         exp_retired = 0;
    int         last_acc = 0;
    bit         b2b_mode = 1'b0;
    bit         last_b2b = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bench-owned execute unit, also the arithmetic reference for expected results.
    function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            OP_SUB:  return a - b;
            OP_ADD:  return a + b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_SHR:  return a >> b;
            OP_SHL:  return a << b;
            OP_LT:   return {3'b000, (a < b)};
            OP_EQ:   return {3'b000, (a == b)};
            default: return 4'd0;
        endcase
    endfunction

    assign exe_out = alu_ref(exe_sel, exe_rs, exe_rt);

    alu_issue_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .load_valid  (load_valid),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .exe_rs      (exe_rs),
        .exe_rt      (exe_rt),
        .exe_sel     (exe_sel),
        .exe_out     (exe_out),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
`ifdef ISSUE_CNT_EN
        ,
        .retired     (retired)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: records accepts and scores every writeback against the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            acc_q.delete();
            last_b2b = 1'b0;
        end else begin
            if (instr_valid && instr_ready) begin
                if (b2b_mode && last_b2b) check("accept_spacing", cyc - last_acc, 4);
                last_acc = cyc;
                last_b2b = b2b_mode;
                acc_q.push_back(cyc);
            end
            if (wb_valid) begin
                if (sb_q.size() == 0) begin
                    check("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("wb_rd", wb_rd, e.rd);
                    check("wb_data", wb_data, e.data);
                    check("exe_rs", exe_rs, e.rs);
                    check("exe_rt", exe_rt, e.rt);
                    check("exe_sel", exe_sel, e.sel);
                    if (acc_q.size() == 0) check("wb_no_accept", 32'd1, 32'd0);
                    else check("wb_latency", cyc - acc_q.pop_front(), 3);
                end
            end
        end
    end

    // Called at posedge+1 with the issuer idle; returns at posedge+1 after the WB edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input int lph, input logic [1:0] la, input logic [3:0] ld);
        exp_t e;
        int   waited = 0;
        instr       = {op, rd, ra, rb};
        instr_valid = 1'b1;
        while (!instr_ready) begin
            @(posedge clk); #1;
            waited++;
            if (waited > 10) begin
                check("ready_timeout", 32'd0, 32'd1);
                instr_valid = 1'b0;
                return;
            end
        end
        load_valid = (lph == 0);
        load_addr  = la;
        load_data  = ld;
        if (lph == 0) model_rf[la] = ld;
        e.rd   = rd;
        e.rs   = model_rf[ra];
        e.rt   = model_rf[rb];
        e.sel  = op;
        e.data = alu_ref(op, e.rs, e.rt);
        sb_q.push_back(e);
        for (int p = 1; p <= 3; p++) begin
            @(posedge clk); #1;
            check("ready_busy", instr_ready, 1'b0);
            instr_valid = 1'($urandom_range(0, 1));
            instr       = 9'($urandom);
            load_valid  = (lph == p);
            if (lph == p) model_rf[la] = ld;
        end
        @(posedge clk); #1;
        check("ready_after_wb", instr_ready, 1'b1);
        instr_valid  = 1'b0;
        load_valid   = 1'b0;
        model_rf[rd] = e.data;
        exp_retired++;
`ifdef ISSUE_CNT_EN
        check("retired", retired, 32'(exp_retired[7:0]));
`endif
    endtask

    task automatic do_load(input logic [1:0] a, input logic [3:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        @(posedge clk); #1;
        load_valid  = 1'b0;
        model_rf[a] = d;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        load_valid  = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) model_rf[i] = 4'd0;
        exp_retired = 0;
    endtask

    task automatic check_reset_values();
        check("rst_ready", instr_ready, 1'b1);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_exe_rs", exe_rs, 4'd0);
        check("rst_exe_rt", exe_rt, 4'd0);
        check("rst_exe_sel", exe_sel, 3'd0);
        check("rst_wb_rd", wb_rd, 2'd0);
        check("rst_wb_data", wb_data, 4'd0);
`ifdef ISSUE_CNT_EN
        check("rst_retired", retired, 8'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 9'd0;
        load_valid  = 1'b0;
        load_addr   = 2'd0;
        load_data   = 4'd0;
        do_reset();
        check_reset_values();

        do_load(2'd1, 4'd3);
        do_load(2'd2, 4'd5);
        issue(OP_ADD, 2'd0, 2'd1, 2'd2, 4, 2'd0, 4'd0);
        issue(OP_SUB, 2'd3, 2'd1, 2'd2, 4, 2'd0, 4'd0);
        issue(OP_OR,  2'd0, 2'd1, 2'd2, 4, 2'd0, 4'd0);

        // Same-edge load and writeback to r0, then a load to r1 on the READ edge.
        do_load(2'd1, 4'd1);
        issue(OP_ADD, 2'd0, 2'd1, 2'd1, 3, 2'd0, 4'd9);
        issue(OP_OR,  2'd2, 2'd0, 2'd0, 4, 2'd0, 4'd0);
        issue(OP_ADD, 2'd3, 2'd1, 2'd1, 1, 2'd1, 4'd15);
        issue(OP_AND, 2'd3, 2'd1, 2'd1, 4, 2'd0, 4'd0);

        b2b_mode = 1'b1;
        for (int n = 0; n < 150; n++) begin
            issue(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom),
                  $urandom_range(0, 4), 2'($urandom), 4'($urandom));
        end
        b2b_mode = 1'b0;

        // Reset while the instruction is in EXEC: its writeback must never appear.
        do_load(2'd3, 4'd6);
        instr       = {OP_ADD, 2'd0, 2'd3, 2'd3};
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        do_reset();
        check_reset_values();
        repeat (5) begin
            @(posedge clk); #1;
        end
        for (int r = 0; r < 4; r++) begin
            issue(OP_OR, 2'(r), 2'(r), 2'(r), 4, 2'd0, 4'd0);
        end

`ifdef ISSUE_CNT_EN
        do_reset();
        for (int n = 0; n < 257; n++) begin
            issue(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom), 4, 2'd0, 4'd0);
        end
        check("retired_wrap", retired, 8'd1);
`endif

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
